tile_cfg_sink: RTL and testbench
================================

# tile_cfg_sink

Tile-side endpoint of the serial configuration bus. Each cycle it samples one address/data beat, decodes the tile and feature fields, and writes the data into a shadow register bank. On an explicit commit it copies the shadow bank to the active bank that drives the tile datapath. It also returns readback data to the configuration master.

## Interface
Parameters:
- NREGS, 8: number of 32-bit configuration registers; legal range 1..254.
- FEATURE_ID, 8'h00: feature field value this instance answers to.

Ports (all synchronous to clk):
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- tile_id  in  16  static tile identifier, strapped at top level.
- cfg_valid  in  1  beat present this cycle.
- cfg_write  in  1  1 = write beat, 0 = read beat.
- cfg_addr  in  32  [15:0] tile, [23:16] feature, [31:24] register index.
- cfg_data  in  32  write data; ignored on reads.
- cfg_regs  out  NREGS*32  active bank; register i occupies bits [32i+31:32i].
- cfg_busy  out  1  shadow bank differs from active bank (uncommitted writes exist).
- cfg_done  out  1  one-cycle pulse after a commit.
- cfg_err  out  1  sticky error flag.
- rd_data  out  32  readback data.
- rd_valid  out  1  rd_data qualifier, one-cycle pulse.

## Operation
- **Match.** A beat matches when the tile field equals tile_id and the feature field equals FEATURE_ID.
  - A tile field of 16'hFFFF also matches, but for writes only. Broadcast reads are dropped, with no response and no error.
- **Write, index < NREGS.** shadow[index] <= cfg_data.
- **Write, index 8'hFF (commit).** Active bank <= shadow bank. cfg_data is ignored.
- **Write, any other index.** No write occurs; cfg_err is set.
- **Read, index < NREGS.** Returns shadow[index].
- **Read, index 8'hFE.** Returns the status word {29'b0, cfg_err, cfg_busy, state==COMMIT}.
- **Read, any other index.** Returns 32'h0 and sets cfg_err.
- **Unmatched beats** are ignored entirely.
- **State machine** (2 bits):
  - IDLE: a matched shadow write goes to DIRTY. A commit goes to COMMIT.
  - DIRTY: a commit goes to COMMIT. Further writes stay in DIRTY.
  - COMMIT: lasts exactly one cycle. A matched shadow write in this cycle goes to DIRTY; otherwise the next state is IDLE. A commit in this cycle re-enters COMMIT.
- cfg_busy = (state==DIRTY). cfg_done = (state==COMMIT).
- **Reset values:** all shadow and active registers 0, state IDLE, cfg_busy/cfg_done/cfg_err/rd_valid 0, rd_data 0. The input stage register is also cleared, so a beat captured before a mid-stream reset is discarded.

## Timing
- **Stage 0:** beat sampled on edge E into the input register.
- **Stage 1:** decode. The shadow write, active copy and state update happen on edge E+1.
  - cfg_regs reflects a commit from E+1.
  - cfg_done is high for the cycle following E+1.
- **Stage 2:** readback. rd_data/rd_valid are registered on edge E+2, so read latency is 2 cycles.
- **Back-to-back beats** are accepted every cycle; there is no backpressure.
- **Read after write to the same index:** if the read beat directly follows the write, it returns the new value, because the shadow write at E+1 precedes the read's decode at E+2.
- **Commit directly after a write** includes that write. The shadow-to-active copy uses shadow contents plus the write decoded in the same cycle; in-order beats never have both decoded together.
- **Write in the cycle before reset deasserts:** dropped.

## Configuration
- Macro: CFG_SINK_READBACK_EN.
- **Defined:** read beats, the 8'hFE status read, and the rd_data/rd_valid pipeline are implemented as above.
- **Undefined:**
  - rd_data is tied to 32'h0 and rd_valid to 0.
  - Read beats are ignored and never set cfg_err.
  - No stage-2 flops are synthesised.
  - Write and commit behaviour is unchanged.

## Test plan
- **Write, then commit.** Reset, then write tile_id=16'h0003 index 2 data 32'hDEADBEEF.
  - cfg_busy=1 and cfg_regs[95:64] is still 0.
  - Commit (index 8'hFF): cfg_regs[95:64]=32'hDEADBEEF one cycle later, cfg_done pulses once, cfg_busy=0.
- **Broadcast write.** Addr 32'h02_00_FFFF, data 32'h1234 then commit: register 2 is updated.
  - Broadcast read of the same address: rd_valid stays 0.
- **Unmatched tile.** Write with tile field 16'h0004 on the tile_id=3 instance: no state change, cfg_busy stays 0.
- **Out-of-range index.** Write to index NREGS (8): cfg_err=1 and stays 1.
  - Status read (index 8'hFE) returns 32'h4; reset clears it.
- **Back-to-back write, read, commit.** Write index 1 = 32'hA5A5A5A5, then read index 1 on the next cycle, then commit.
  - rd_valid comes 2 cycles after the read beat with rd_data=32'hA5A5A5A5.
  - cfg_done pulses.
  - Write during the COMMIT cycle: state goes to DIRTY.
- **Reset mid-stream.** Drive reset low while a write beat sits in stage 0.
  - All outputs are 0 after release.
  - A subsequent commit leaves cfg_regs all zero.

Source files
------------

// File: rtl/tile_cfg_sink.sv
// Tile-side config bus endpoint: shadow/active register bank with commit, sticky error and readback.
// Optional readback path (reads, status word, rd_data/rd_valid pipeline) is enabled by CFG_SINK_READBACK_EN.
module tile_cfg_sink #(
  parameter int         NREGS      = 8,
  parameter logic [7:0] FEATURE_ID = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          tile_id,
  input  logic                 cfg_valid,
  input  logic                 cfg_write,
  input  logic [31:0]          cfg_addr,
  input  logic [31:0]          cfg_data,
  output logic [NREGS*32-1:0]  cfg_regs,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic [31:0]          rd_data,
  output logic                 rd_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRTY  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        in_valid, in_write;
  logic [31:0] in_addr, in_data;
  logic [31:0] shadow [NREGS];
  logic [31:0] active [NREGS];

  logic [15:0] tile_f;
  logic [7:0]  feat_f, idx;
  logic        feat_ok, in_range, wr_match, shadow_wr, commit, wr_bad, err_set;

  // Stage 0: input capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_valid <= 1'b0;
      in_write <= 1'b0;
      in_addr  <= '0;
      in_data  <= '0;
    end else begin
      in_valid <= cfg_valid;
      in_write <= cfg_write;
      in_addr  <= cfg_addr;
      in_data  <= cfg_data;
    end
  end

  // Stage 1: decode.
  assign tile_f    = in_addr[15:0];
  assign feat_f    = in_addr[23:16];
  assign idx       = in_addr[31:24];
  assign feat_ok   = (feat_f == FEATURE_ID);
  assign in_range  = (int'(idx) < NREGS);
  assign wr_match  = in_valid && in_write && feat_ok &&
                     ((tile_f == tile_id) || (tile_f == 16'hFFFF));
  assign shadow_wr = wr_match && in_range;
  assign commit    = wr_match && (idx == 8'hFF);
  assign wr_bad    = wr_match && !in_range && (idx != 8'hFF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (commit) state_next = COMMIT;
               else if (shadow_wr) state_next = DIRTY;
      DIRTY:   if (commit) state_next = COMMIT;
      COMMIT:  if (commit) state_next = COMMIT;
               else if (shadow_wr) state_next = DIRTY;
               else state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cfg_busy = (state == DIRTY);
  assign cfg_done = (state == COMMIT);

  // A commit and a shadow write are never decoded in the same cycle, so copying shadow as-is suffices.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (shadow_wr && (idx == 8'(i))) shadow[i] <= in_data;
        if (commit) active[i] <= shadow[i];
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign cfg_regs[32*g +: 32] = active[g];
  end

`ifdef CFG_SINK_READBACK_EN
  logic        rd_match, rd_bad;
  logic [31:0] rd_word;
  logic        rd1_valid;
  logic [31:0] rd1_data;

  // Broadcast tile field never matches a read.
  assign rd_match = in_valid && !in_write && feat_ok && (tile_f == tile_id);
  assign rd_bad   = rd_match && !in_range && (idx != 8'hFE);
  assign err_set  = wr_bad || rd_bad;

  always_comb begin
    rd_word = '0;
    if (idx == 8'hFE) begin
      rd_word = {29'b0, cfg_err, cfg_busy, cfg_done};
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (idx == 8'(i)) rd_word = shadow[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd1_valid <= 1'b0;
      rd1_data  <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd1_valid <= rd_match;
      rd1_data  <= rd_match ? rd_word : 32'h0;
      rd_valid  <= rd1_valid;
      rd_data   <= rd1_data;
    end
  end
`else
  assign err_set  = wr_bad;
  assign rd_data  = 32'h0;
  assign rd_valid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg_err <= 1'b0;
    end else if (err_set) begin
      cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tile_cfg_sink.sv
// Directed self-checking bench for tile_cfg_sink (tile_id 3, NREGS 8, FEATURE_ID 0).
module tb_tile_cfg_sink;
  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  tile_id;
  logic         cfg_valid, cfg_write;
  logic [31:0]  cfg_addr, cfg_data;
  logic [255:0] cfg_regs;
  logic         cfg_busy, cfg_done, cfg_err;
  logic [31:0]  rd_data;
  logic         rd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  tile_cfg_sink #(.NREGS(8), .FEATURE_ID(8'h00)) dut (
    .clk(clk), .reset(reset), .tile_id(tile_id),
    .cfg_valid(cfg_valid), .cfg_write(cfg_write), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_regs(cfg_regs), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [7:0] idx, input logic [15:0] tile);
    return {idx, 8'h00, tile};
  endfunction

  // Inputs change on the falling edge; the task returns one falling edge later.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    cfg_valid = 1'b1; cfg_write = w; cfg_addr = a; cfg_data = d;
    @(negedge clk);
  endtask

  task automatic idle();
    cfg_valid = 1'b0; cfg_write = 1'b0; cfg_addr = '0; cfg_data = '0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(); idle();
    reset = 1'b1;
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (cfg_regs !== 256'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", cfg_regs); end
    n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", cfg_busy); end
    n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", cfg_done); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    n_checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd: got %b/%h want 0/0", rd_valid, rd_data); end
  endtask

  task automatic test_write_commit();
    send(1'b1, mk(8'd2, 16'h0003), 32'hDEADBEEF);
    idle();
    n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL wc_busy: got %b want 1", cfg_busy); end
    n_checks++; if (cfg_regs[95:64] !== 32'h0) begin n_fail++; $display("FAIL wc_pre: got %h want 0", cfg_regs[95:64]); end
    send(1'b1, mk(8'hFF, 16'h0003), 32'h1111_1111);
    idle();
    n_checks++; if (cfg_regs[95:64] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wc_reg2: got %h want deadbeef", cfg_regs[95:64]); end
    n_checks++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL wc_done: got %b want 1", cfg_done); end
    n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL wc_busy_after: got %b want 0", cfg_busy); end
    idle();
    n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL wc_done_pulse: got %b want 0", cfg_done); end
  endtask

  task automatic test_broadcast();
    logic seen;
    send(1'b1, mk(8'd2, 16'hFFFF), 32'h0000_1234);
    send(1'b1, mk(8'hFF, 16'h0003), 32'h0);
    idle(); idle();
    n_checks++; if (cfg_regs[95:64] !== 32'h0000_1234) begin n_fail++; $display("FAIL bc_reg2: got %h want 1234", cfg_regs[95:64]); end
    send(1'b0, mk(8'd2, 16'hFFFF), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rd_valid !== 1'b0) seen = 1'b1;
      idle();
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bc_read: rd_valid seen %b want 0", seen); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL bc_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_unmatched();
    send(1'b1, mk(8'd5, 16'h0004), 32'h77);
    send(1'b1, {8'd6, 8'h01, 16'h0003}, 32'h88);
    idle(); idle();
    n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL um_busy: got %b want 0", cfg_busy); end
    send(1'b1, mk(8'hFF, 16'h0004), 32'h0);
    idle();
    n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL um_done: got %b want 0", cfg_done); end
    n_checks++; if (cfg_regs !== {160'h0, 32'h0000_1234, 64'h0}) begin n_fail++; $display("FAIL um_regs: got %h", cfg_regs); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL um_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_out_of_range();
    send(1'b1, mk(8'd8, 16'h0003), 32'h99);
    idle();
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", cfg_err); end
    n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL oor_busy: got %b want 0", cfg_busy); end
    idle(); idle(); idle();
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL oor_sticky: got %b want 1", cfg_err); end
    send(1'b0, mk(8'hFE, 16'h0003), 32'h0);
    idle(); idle();
`ifdef CFG_SINK_READBACK_EN
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h4) begin
      n_fail++; $display("FAIL oor_status: got %b/%h want 1/00000004", rd_valid, rd_data); end
    idle();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL oor_rd_pulse: got %b want 0", rd_valid); end
`else
    n_checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL oor_status_off: got %b/%h want 0/0", rd_valid, rd_data); end
`endif
    do_reset();
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL oor_reset_err: got %b want 0", cfg_err); end
    n_checks++; if (cfg_regs !== 256'h0) begin n_fail++; $display("FAIL oor_reset_regs: got %h want 0", cfg_regs); end
  endtask

  task automatic test_back_to_back();
    send(1'b1, mk(8'd1, 16'h0003), 32'hA5A5A5A5);
    send(1'b0, mk(8'd1, 16'h0003), 32'h0);
    send(1'b1, mk(8'hFF, 16'h0003), 32'h0);
    send(1'b1, mk(8'd3, 16'h0003), 32'h11);
`ifdef CFG_SINK_READBACK_EN
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL b2b_read: got %b/%h want 1/a5a5a5a5", rd_valid, rd_data); end
`else
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_read_off: got %b want 0", rd_valid); end
`endif
    n_checks++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", cfg_done); end
    n_checks++; if (cfg_regs[63:32] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_reg1: got %h want a5a5a5a5", cfg_regs[63:32]); end
    idle();
    n_checks++; if (cfg_busy !== 1'b1 || cfg_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_dirty: got busy %b done %b want 1/0", cfg_busy, cfg_done); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_pulse: got %b want 0", rd_valid); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", cfg_err); end
    send(1'b1, mk(8'hFF, 16'h0003), 32'h0);
    idle();
    n_checks++; if (cfg_regs !== {128'h0, 32'h11, 32'h0, 32'hA5A5A5A5, 32'h0}) begin
      n_fail++; $display("FAIL b2b_recommit: got %h", cfg_regs); end
    idle();
  endtask

  task automatic test_reset_mid();
    send(1'b1, mk(8'd0, 16'h0003), 32'hCAFE);
    reset = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    send(1'b1, mk(8'd4, 16'h0003), 32'h55);
    reset = 1'b1;
    idle(); idle();
    n_checks++; if (cfg_regs !== 256'h0) begin n_fail++; $display("FAIL mid_regs: got %h want 0", cfg_regs); end
    n_checks++; if ({cfg_busy, cfg_done, cfg_err, rd_valid} !== 4'b0 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL mid_outs: got b%b d%b e%b v%b %h want 0", cfg_busy, cfg_done, cfg_err, rd_valid, rd_data); end
    send(1'b1, mk(8'hFF, 16'h0003), 32'h0);
    idle();
    n_checks++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL mid_done: got %b want 1", cfg_done); end
    n_checks++; if (cfg_regs !== 256'h0) begin n_fail++; $display("FAIL mid_commit_regs: got %h want 0", cfg_regs); end
  endtask

  initial begin
    tile_id = 16'h0003;
    reset = 1'b0;
    cfg_valid = 1'b0; cfg_write = 1'b0; cfg_addr = '0; cfg_data = '0;
    @(negedge clk);
    test_reset();
    test_write_commit();
    test_broadcast();
    test_unmatched();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
